// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encodings, the FSM state type and the default operand width.
package muldiv_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // Op encodings. Bit 1 selects divide; bit 0 selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration shared by multiply and divide.
//   is_div_i  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_hi_i  : upper accumulator (product high half / partial remainder)
//   acc_lo_i  : lower accumulator (multiplier bits / dividend-then-quotient bits)
//   operand_i : multiplicand or divisor magnitude
//   acc_hi_o, acc_lo_o : accumulator after this iteration
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             unused_bits;

  always_comb begin
    // Multiply: add multiplicand if multiplier LSB set, then shift {carry, hi, lo} right.
    sum    = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, operand_i} : '0);
    // Divide: shift next dividend bit into the remainder and trial-subtract.
    rem_sh = {acc_hi_i, acc_lo_i[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, operand_i};
    if (is_div_i) begin
      if (diff[WIDTH+1]) begin
        // Borrow: restore. rem_sh < divisor here, so its top bit is zero.
        acc_hi_o = rem_sh[WIDTH-1:0];
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_hi_o = diff[WIDTH-1:0];
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_hi_o = sum[WIDTH:1];
      acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end

  // These bits are provably zero on the paths that keep them.
  assign unused_bits = diff[WIDTH] ^ rem_sh[WIDTH];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the MIPS HI/LO registers.
//   clk, rst_n     : clock, synchronous active-low reset
//   start, op      : launch MULT/MULTU/DIV/DIVU (accepted only when idle)
//   rs_val, rt_val : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo     : write rs_val to HI/LO (accepted only when idle and no start)
//   hi, lo         : HI/LO registers
//   busy           : operation in flight (RUN or FIX)
//   done           : one-cycle pulse after HI/LO take a result
// Start at edge E0, 32 iterations at E1..E32, sign fix-up and HI/LO write at E33.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             signed_op, is_div, rs_neg, rt_neg, last_iter;
  logic [WIDTH-1:0] rs_mag, rt_mag, step_hi, step_lo, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div_i  (op_q[1]),
    .acc_hi_i  (acc_hi_q),
    .acc_lo_i  (acc_lo_q),
    .operand_i (operand_q),
    .acc_hi_o  (step_hi),
    .acc_lo_o  (step_lo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_iter) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and output next-state logic.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    rs_neg    = signed_op & rs_val[WIDTH-1];
    rt_neg    = signed_op & rt_val[WIDTH-1];
    // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude.
    rs_mag    = rs_neg ? -rs_val : rs_val;
    rt_mag    = rt_neg ? -rt_val : rt_val;

    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = res_neg_q ? -prod : prod;
    // Divide by zero: quotient forced to all ones; remainder fix-up restores rs_val.
    quo_fix  = (operand_q == '0) ? '1 : (res_neg_q ? -acc_lo_q : acc_lo_q);
    rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;

    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    operand_d = operand_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    busy_d    = (state_d != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d      = op;
          cnt_d     = '0;
          acc_hi_d  = '0;
          acc_lo_d  = is_div ? rs_mag : rt_mag;
          operand_d = is_div ? rt_mag : rs_mag;
          res_neg_d = rs_neg ^ rt_neg;
          rem_neg_d = rs_neg;
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      StRun: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      StFix: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d = 1'b1;
        cnt_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      operand_q <= operand_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: expected HI/LO pairs are queued when an
// operation is launched and compared when done pulses.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] rs_val, rt_val, hi, lo;
  logic         busy, done;

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  logic [63:0]  sb[$];
  logic [63:0]  popped;
  logic [W-1:0] hi_exp = '0;
  logic [W-1:0] lo_exp = '0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH (W),
    .CNT_W (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic, MIPS semantics including divide-by-zero and overflow.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [31:0] sa, sbv, q, r;
    sa  = a;
    sbv = b;
    case (o)
      OP_MULT: begin
        p = 64'(sa) * 64'(sbv);
        return p;
      end
      OP_MULTU: return {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        popped = sb.pop_front();
        check("hi_result", 64'(hi), 64'(popped[63:32]));
        check("lo_result", 64'(lo), 64'(popped[31:0]));
        hi_exp = popped[63:32];
        lo_exp = popped[31:0];
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input logic with_mtlo);
    int n;
    sb.push_back(exp);
    op     = o;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    mtlo   = with_mtlo;
    @(posedge clk); #1;
    start = 1'b0;
    mtlo  = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("lo_hold_at_start", 64'(lo), 64'(lo_exp));
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 16) begin
        check("hi_hold_run", 64'(hi), 64'(hi_exp));
        check("lo_hold_run", 64'(lo), 64'(lo_exp));
        check("done_low_run", 64'(done), 64'd0);
      end
    end
    check("busy_cycles", 64'(n), 64'd33);
    check("done_pulse", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = OP_MULT; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    issue(OP_DIVU,  32'd7,         32'd0,         {32'h0000_0007, 32'hFFFF_FFFF}, 1'b0);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0);
    issue(OP_DIV,   32'hFFFF_FFF0, 32'd0,         {32'hFFFF_FFF0, 32'hFFFF_FFFF}, 1'b0);
    issue(OP_MULT,  32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, 1'b0);

    // Requests while busy are ignored.
    sb.push_back({32'h0, 32'd15});
    op = OP_MULTU; rs_val = 32'd3; rt_val = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    op = OP_DIVU; rs_val = 32'hAAAA_5555; start = 1'b1; mthi = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("hi_ignores_busy_mthi", 64'(hi), 64'(hi_exp));
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    check("busy_tail_cycles", 64'(n), 64'd23);
    repeat (40) begin @(posedge clk); #1; end
    check("no_second_op_busy", 64'(busy), 64'd0);
    check("busy_test_hi", 64'(hi), 64'd0);
    check("busy_test_lo", 64'(lo), 64'd15);

    // Idle moves, then start+mtlo where mtlo is dropped.
    rs_val = 32'h1234_5678; mthi = 1'b1; mtlo = 1'b1;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    hi_exp = 32'h1234_5678;
    lo_exp = 32'h1234_5678;
    check("mthi_idle", 64'(hi), 64'h1234_5678);
    check("mtlo_idle", 64'(lo), 64'h1234_5678);
    check("move_no_done", 64'(done), 64'd0);
    check("move_no_busy", 64'(busy), 64'd0);
    issue(OP_MULTU, 32'd6, 32'd7, {32'h0, 32'd42}, 1'b1);

    // Random operations against the reference model.
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom;
      issue(ro, ra, rb, model(ro, ra, rb), 1'b0);
    end

    // Reset in the middle of a divide aborts it without a done.
    op = OP_DIV; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    hi_exp = '0;
    lo_exp = '0;
    repeat (40) begin @(posedge clk); #1; end
    check("abort_stays_idle", 64'(busy), 64'd0);
    issue(OP_DIV, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
